// File: rtl/spi_frame_ctrl.sv
// Frame sequencer in front of the SPI byte master: paces slave select, setup/gap
// timing and the send/busy/ack handshake per byte, returning each MISO byte.
module spi_frame_ctrl #(
    parameter int unsigned CLK_DIV     = 4,    // >= 2
    parameter int unsigned SETUP_TICKS = 2,    // >= 1
    parameter int unsigned GAP_TICKS   = 1,    // >= 1
    parameter int unsigned TIMEOUT     = 1023  // >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       timeout_err,
    output logic       ena_2clk,
    output logic       spi_ss_n,
    output logic       spi_send,
    output logic       spi_ack,
    output logic [7:0] data_spi,
    input  logic       busy_spi,
    input  logic [7:0] rx_spi
);

    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned TICK_MAX = (SETUP_TICKS > GAP_TICKS) ? SETUP_TICKS : GAP_TICKS;
    localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);
    localparam int unsigned CYC_W    = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] SETUP_LAST   = TICK_W'(SETUP_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST     = TICK_W'(GAP_TICKS - 1);
    localparam logic [CYC_W-1:0]  TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, SEND, WAIT_BUSY, WAIT_DONE, GAP, HOLD
    } state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  div_cnt, div_d;
    logic [TICK_W-1:0] tick_cnt, tick_d;
    logic [CYC_W-1:0]  cyc_cnt, cyc_d;
    logic              last_q, last_d;
    logic [7:0]        data_spi_d, rx_data_d;
    logic              tx_ready_d, rx_valid_d, frame_busy_d, frame_done_d;
    logic              timeout_err_d, ss_n_d, spi_send_d, spi_ack_d;

    always_comb begin
        div_d = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    // ena_2clk is registered so it is high exactly while the divider holds CLK_DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            ena_2clk <= 1'b0;
        end else begin
            div_cnt  <= div_d;
            ena_2clk <= (div_d == DIV_LAST);
        end
    end

    always_comb begin
        state_d       = state;
        tick_d        = tick_cnt;
        cyc_d         = cyc_cnt;
        last_d        = last_q;
        data_spi_d    = data_spi;
        rx_data_d     = rx_data;
        ss_n_d        = spi_ss_n;
        frame_busy_d  = frame_busy;
        rx_valid_d    = 1'b0;
        spi_send_d    = 1'b0;
        spi_ack_d     = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_d      = SETUP;
                    ss_n_d       = 1'b0;
                    frame_busy_d = 1'b1;
                    tick_d       = '0;
                end
            end
            SETUP: begin
                if (ena_2clk) begin
                    if (tick_cnt == SETUP_LAST) state_d = LOAD;
                    else                        tick_d  = tick_cnt + 1'b1;
                end
            end
            LOAD: begin
                if (tx_valid) begin
                    data_spi_d = tx_data;
                    last_d     = tx_last;
                    spi_send_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_BUSY;
                cyc_d   = '0;
            end
            WAIT_BUSY: begin
                if (busy_spi) begin
                    state_d = WAIT_DONE;
                    cyc_d   = '0;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    spi_ack_d     = 1'b1;
                    ss_n_d        = 1'b1;
                    frame_busy_d  = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cyc_d = cyc_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_spi) begin
                    rx_data_d  = rx_spi;
                    rx_valid_d = 1'b1;
                    spi_ack_d  = 1'b1;
                    tick_d     = '0;
                    state_d    = GAP;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
                    // ack still pulses on abort so the master drops its IRQ
                    timeout_err_d = 1'b1;
                    spi_ack_d     = 1'b1;
                    ss_n_d        = 1'b1;
                    frame_busy_d  = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cyc_d = cyc_cnt + 1'b1;
                end
            end
            GAP: begin
                if (ena_2clk) begin
                    if (tick_cnt == GAP_LAST) state_d = last_q ? HOLD : LOAD;
                    else                      tick_d  = tick_cnt + 1'b1;
                end
            end
            HOLD: begin
                ss_n_d       = 1'b1;
                frame_done_d = 1'b1;
                frame_busy_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tx_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            cyc_cnt     <= '0;
            last_q      <= 1'b0;
            tx_ready    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            spi_ss_n    <= 1'b1;
            spi_send    <= 1'b0;
            spi_ack     <= 1'b0;
            data_spi    <= '0;
        end else begin
            state       <= state_d;
            tick_cnt    <= tick_d;
            cyc_cnt     <= cyc_d;
            last_q      <= last_d;
            tx_ready    <= tx_ready_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            frame_busy  <= frame_busy_d;
            frame_done  <= frame_done_d;
            timeout_err <= timeout_err_d;
            spi_ss_n    <= ss_n_d;
            spi_send    <= spi_send_d;
            spi_ack     <= spi_ack_d;
            data_spi    <= data_spi_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: behavioural SPI master model, negedge
// monitor recording handshake timing, and one task per scenario.
module tb_spi_frame_ctrl;

    localparam int M_LOOP  = 0;
    localparam int M_INDEX = 1;
    localparam int M_DEAD  = 2;
    localparam int M_STUCK = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_busy, frame_done, timeout_err, ena_2clk;
    logic       spi_ss_n, spi_send, spi_ack;
    logic [7:0] data_spi;
    logic       busy_spi;
    logic [7:0] rx_spi;

    logic [7:0] d2_rx_data, d2_data_spi, d7_rx_data, d7_data_spi;
    logic d2_tx_ready, d2_rx_valid, d2_frame_busy, d2_frame_done, d2_timeout_err;
    logic d2_ena, d2_ss_n, d2_send, d2_ack;
    logic d7_tx_ready, d7_rx_valid, d7_frame_busy, d7_frame_done, d7_timeout_err;
    logic d7_ena, d7_ss_n, d7_send, d7_ack;

    int tests_run = 0;
    int fails     = 0;
    int mode      = M_LOOP;

    always #5 clk = ~clk;

    spi_frame_ctrl #(.CLK_DIV(4), .SETUP_TICKS(2), .GAP_TICKS(1), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .frame_busy(frame_busy),
        .frame_done(frame_done), .timeout_err(timeout_err), .ena_2clk(ena_2clk),
        .spi_ss_n(spi_ss_n), .spi_send(spi_send), .spi_ack(spi_ack), .data_spi(data_spi),
        .busy_spi(busy_spi), .rx_spi(rx_spi)
    );

    spi_frame_ctrl #(.CLK_DIV(2)) dut_d2 (
        .clk(clk), .rst(rst), .tx_data(8'h00), .tx_valid(1'b0), .tx_last(1'b0),
        .tx_ready(d2_tx_ready), .rx_data(d2_rx_data), .rx_valid(d2_rx_valid),
        .frame_busy(d2_frame_busy), .frame_done(d2_frame_done), .timeout_err(d2_timeout_err),
        .ena_2clk(d2_ena), .spi_ss_n(d2_ss_n), .spi_send(d2_send), .spi_ack(d2_ack),
        .data_spi(d2_data_spi), .busy_spi(1'b0), .rx_spi(8'h00)
    );

    spi_frame_ctrl #(.CLK_DIV(7)) dut_d7 (
        .clk(clk), .rst(rst), .tx_data(8'h00), .tx_valid(1'b0), .tx_last(1'b0),
        .tx_ready(d7_tx_ready), .rx_data(d7_rx_data), .rx_valid(d7_rx_valid),
        .frame_busy(d7_frame_busy), .frame_done(d7_frame_done), .timeout_err(d7_timeout_err),
        .ena_2clk(d7_ena), .spi_ss_n(d7_ss_n), .spi_send(d7_send), .spi_ack(d7_ack),
        .data_spi(d7_data_spi), .busy_spi(1'b0), .rx_spi(8'h00)
    );

    // SPI master model: busy two cycles after send, done six cycles later
    initial begin : master
        logic [7:0] sent;
        logic [7:0] byte_idx;
        busy_spi = 1'b0;
        rx_spi   = 8'h00;
        byte_idx = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_ss_n) byte_idx = 8'h00;
            if (spi_send && mode != M_DEAD) begin
                sent = data_spi;
                repeat (2) @(negedge clk);
                busy_spi = 1'b1;
                repeat (6) @(negedge clk);
                while (mode == M_STUCK) @(negedge clk);
                rx_spi   = (mode == M_INDEX) ? (8'hF0 + byte_idx) : sent;
                byte_idx = byte_idx + 8'd1;
                busy_spi = 1'b0;
            end
        end
    end

    int         cyc = 0;
    int         n_send = 0, n_ack = 0, n_done = 0, n_tmo = 0, n_rise = 0;
    int         n_bad_send = 0, n_rx_no_ack = 0;
    int         send_cyc = 0, tmo_cyc = 0;
    int         ena_cnt = 0, setup_seen = 0, gap_seen = 0;
    logic       prev_ss = 1'b1, first_send = 1'b0, done_at_rise = 1'b0;
    logic       tmo_with_ack = 1'b0, tmo_ss = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_ss <= spi_ss_n;
        if (spi_send) begin
            n_send   <= n_send + 1;
            send_cyc <= cyc;
        end
        if (spi_send && spi_ss_n) n_bad_send <= n_bad_send + 1;
        if (spi_ack) n_ack <= n_ack + 1;
        if (frame_done) n_done <= n_done + 1;
        if (rx_valid) rx_q.push_back(rx_data);
        if (rx_valid && !spi_ack) n_rx_no_ack <= n_rx_no_ack + 1;
        if (timeout_err) begin
            n_tmo        <= n_tmo + 1;
            tmo_cyc      <= cyc;
            tmo_with_ack <= spi_ack;
            tmo_ss       <= spi_ss_n;
        end
        if (!spi_ss_n && prev_ss)  ena_cnt <= int'(ena_2clk);
        else if (spi_ack)          ena_cnt <= int'(ena_2clk);
        else if (ena_2clk)         ena_cnt <= ena_cnt + 1;
        if (spi_send && first_send) begin
            setup_seen <= ena_cnt;
            first_send <= 1'b0;
        end
        if (!spi_ss_n && prev_ss) first_send <= 1'b1;
        if (spi_ss_n && !prev_ss) begin
            n_rise       <= n_rise + 1;
            gap_seen     <= ena_cnt;
            done_at_rise <= frame_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = tx_ready;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        @(negedge clk);
        while ((frame_busy || !spi_ss_n) && n < 600) begin
            @(negedge clk);
            n++;
        end
        ok = !frame_busy && spi_ss_n;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic sel_ena(input int which);
        case (which)
            2:       return d2_ena;
            7:       return d7_ena;
            default: return ena_2clk;
        endcase
    endfunction

    task automatic measure_div(input int which, output int period, output int width, output bit ok);
        int n = 0;
        int low = 0;
        width = 0;
        while (sel_ena(which) && n < 60) begin @(negedge clk); n++; end
        while (!sel_ena(which) && n < 60) begin @(negedge clk); n++; end
        while (sel_ena(which) && n < 60) begin @(negedge clk); n++; width++; end
        while (!sel_ena(which) && n < 60) begin @(negedge clk); n++; low++; end
        period = width + low;
        ok = (n < 60);
    endtask

    task automatic test_reset();
        logic [24:0] exp_v, got_v;
        exp_v = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        repeat (3) @(negedge clk);
        got_v = {tx_ready, rx_valid, rx_data, frame_busy, frame_done, timeout_err,
                 spi_ss_n, spi_send, spi_ack, data_spi, ena_2clk};
        tests_run++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL reset_outputs: got %h, expected %h", got_v, exp_v);
        end
        tests_run++;
        if ({d2_ena, d7_ena, d2_ss_n, d7_ss_n} !== 4'b0011) begin
            fails++;
            $display("FAIL reset_div_inst: got %b, expected 0011", {d2_ena, d7_ena, d2_ss_n, d7_ss_n});
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (frame_busy !== 1'b0 || spi_ss_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_idle: busy=%b ss_n=%b, expected 0 1", frame_busy, spi_ss_n);
        end
    endtask

    task automatic test_divider();
        int p, w;
        bit ok;
        int which_tab[3] = '{2, 7, 4};
        for (int i = 0; i < 3; i++) begin
            measure_div(which_tab[i], p, w, ok);
            tests_run++;
            if (!ok) begin
                fails++;
                $display("FAIL div%0d_found: no pulse train, expected pulses", which_tab[i]);
            end
            tests_run++;
            if (p !== which_tab[i]) begin
                fails++;
                $display("FAIL div%0d_period: got %0d, expected %0d", which_tab[i], p, which_tab[i]);
            end
            tests_run++;
            if (w !== 1) begin
                fails++;
                $display("FAIL div%0d_width: got %0d, expected 1", which_tab[i], w);
            end
        end
        tests_run++;
        if (frame_busy !== 1'b0) begin
            fails++;
            $display("FAIL div_idle: frame_busy=%b, expected 0", frame_busy);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        int s0 = n_send, a0 = n_ack, d0 = n_done, q0 = rx_q.size(), x0 = n_rx_no_ack;
        mode = M_LOOP;
        send_byte(8'hA5, 1'b1, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL single_accept: got timeout, expected accept"); end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL single_idle: got busy, expected idle"); end
        tests_run++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'hA5) begin
            fails++;
            $display("FAIL single_rx: got %0d bytes first %h, expected 1 byte a5", rx_q.size() - q0, rx_q[q0]);
        end
        tests_run++;
        if (setup_seen !== 2) begin fails++; $display("FAIL single_setup_ticks: got %0d, expected 2", setup_seen); end
        tests_run++;
        if (gap_seen !== 1) begin fails++; $display("FAIL single_gap_ticks: got %0d, expected 1", gap_seen); end
        tests_run++;
        if (done_at_rise !== 1'b1) begin fails++; $display("FAIL single_done_at_rise: got %b, expected 1", done_at_rise); end
        tests_run++;
        if (n_send - s0 !== 1 || n_ack - a0 !== 1 || n_done - d0 !== 1) begin
            fails++;
            $display("FAIL single_counts: send/ack/done %0d/%0d/%0d, expected 1/1/1", n_send - s0, n_ack - a0, n_done - d0);
        end
        tests_run++;
        if (n_rx_no_ack !== x0) begin fails++; $display("FAIL single_rx_ack_coincide: got %0d misses, expected 0", n_rx_no_ack - x0); end
    endtask

    task automatic test_three_byte();
        bit ok0, ok1, ok2, oki;
        logic [7:0] exp_tab[3] = '{8'hF0, 8'hF1, 8'hF2};
        int s0 = n_send, a0 = n_ack, d0 = n_done, r0 = n_rise, b0 = n_bad_send, q0 = rx_q.size();
        mode = M_INDEX;
        send_byte(8'h01, 1'b0, ok0);
        send_byte(8'h02, 1'b0, ok1);
        send_byte(8'h03, 1'b1, ok2);
        wait_idle(oki);
        tests_run++;
        if (!(ok0 && ok1 && ok2 && oki)) begin
            fails++;
            $display("FAIL three_handshake: got %b%b%b%b, expected 1111", ok0, ok1, ok2, oki);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rx_q[q0 + i] !== exp_tab[i]) begin
                fails++;
                $display("FAIL three_rx%0d: got %h, expected %h", i, rx_q[q0 + i], exp_tab[i]);
            end
        end
        tests_run++;
        if (n_rise - r0 !== 1) begin fails++; $display("FAIL three_ss_continuous: got %0d rises, expected 1", n_rise - r0); end
        tests_run++;
        if (n_send - s0 !== 3 || n_ack - a0 !== 3) begin
            fails++;
            $display("FAIL three_pulses: send/ack %0d/%0d, expected 3/3", n_send - s0, n_ack - a0);
        end
        tests_run++;
        if (n_done - d0 !== 1 || n_bad_send !== b0) begin
            fails++;
            $display("FAIL three_done: done %0d bad_send %0d, expected 1 0", n_done - d0, n_bad_send - b0);
        end
    endtask

    task automatic test_underflow_stall();
        bit ok;
        int n = 0;
        int s1, r1;
        int d0 = n_done, r0 = n_rise, q0 = rx_q.size();
        mode = M_LOOP;
        send_byte(8'h11, 1'b0, ok);
        while (rx_q.size() < q0 + 1 && n < 200) begin @(negedge clk); n++; end
        tests_run++;
        if (rx_q.size() != q0 + 1) begin fails++; $display("FAIL stall_first_rx: got %0d bytes, expected 1", rx_q.size() - q0); end
        s1 = n_send;
        r1 = n_rise;
        repeat (50) @(negedge clk);
        tests_run++;
        if (n_send !== s1) begin fails++; $display("FAIL stall_no_send: got %0d sends, expected 0", n_send - s1); end
        tests_run++;
        if (spi_ss_n !== 1'b0 || n_rise !== r1) begin
            fails++;
            $display("FAIL stall_ss_low: ss_n=%b rises=%0d, expected 0 0", spi_ss_n, n_rise - r1);
        end
        tests_run++;
        if (tx_ready !== 1'b1 || frame_busy !== 1'b1) begin
            fails++;
            $display("FAIL stall_waiting: ready=%b busy=%b, expected 1 1", tx_ready, frame_busy);
        end
        send_byte(8'h22, 1'b0, ok);
        send_byte(8'h33, 1'b1, ok);
        wait_idle(ok);
        tests_run++;
        if (rx_q[q0] !== 8'h11 || rx_q[q0 + 1] !== 8'h22 || rx_q[q0 + 2] !== 8'h33) begin
            fails++;
            $display("FAIL stall_rx: got %h %h %h, expected 11 22 33", rx_q[q0], rx_q[q0 + 1], rx_q[q0 + 2]);
        end
        tests_run++;
        if (n_done - d0 !== 1 || n_rise - r0 !== 1) begin
            fails++;
            $display("FAIL stall_complete: done %0d rises %0d, expected 1 1", n_done - d0, n_rise - r0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        int d0 = n_done, t0 = n_tmo, q0 = rx_q.size();
        mode = M_DEAD;
        send_byte(8'h5A, 1'b1, ok);
        while (n_tmo == t0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        tests_run++;
        if (n_tmo - t0 !== 1) begin fails++; $display("FAIL tmo_pulse: got %0d pulses, expected 1", n_tmo - t0); end
        tests_run++;
        if (tmo_cyc - send_cyc !== 32) begin
            fails++;
            $display("FAIL tmo_latency: got %0d cycles after send, expected 32", tmo_cyc - send_cyc);
        end
        tests_run++;
        if (tmo_with_ack !== 1'b1 || tmo_ss !== 1'b1) begin
            fails++;
            $display("FAIL tmo_ack_ss: ack=%b ss_n=%b, expected 1 1", tmo_with_ack, tmo_ss);
        end
        tests_run++;
        if (n_done !== d0 || rx_q.size() != q0 || frame_busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_no_done: done %0d rx %0d busy %b, expected 0 0 0", n_done - d0, rx_q.size() - q0, frame_busy);
        end
        mode = M_LOOP;
        send_byte(8'h6B, 1'b1, ok);
        wait_idle(ok);
        tests_run++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'h6B || n_done - d0 !== 1) begin
            fails++;
            $display("FAIL tmo_recover: rx %h done %0d, expected 6b 1", rx_q[q0], n_done - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n = 0;
        logic [24:0] exp_v, got_v;
        int d0, q0;
        exp_v = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        d0 = n_done;
        mode = M_STUCK;
        send_byte(8'hC3, 1'b1, ok);
        while (!busy_spi && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy_spi !== 1'b1 || frame_busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_in_flight: busy_spi=%b frame_busy=%b, expected 1 1", busy_spi, frame_busy);
        end
        #2 rst = 1'b0;
        #1;
        got_v = {tx_ready, rx_valid, rx_data, frame_busy, frame_done, timeout_err,
                 spi_ss_n, spi_send, spi_ack, data_spi, ena_2clk};
        tests_run++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL rstmid_outputs: got %h, expected %h", got_v, exp_v);
        end
        mode = M_LOOP;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (n_done !== d0) begin fails++; $display("FAIL rstmid_no_done: got %0d, expected 0", n_done - d0); end
        q0 = rx_q.size();
        send_byte(8'h3C, 1'b1, ok);
        wait_idle(ok);
        tests_run++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'h3C || n_done - d0 !== 1) begin
            fails++;
            $display("FAIL rstmid_recover: rx %h done %0d, expected 3c 1", rx_q[q0], n_done - d0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        test_reset();
        test_divider();
        test_single_byte();
        test_three_byte();
        test_underflow_stall();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
